// File: rtl/uart_tx_prescaled_if.sv
// Parallel-word handshake into the UART transmitter.
interface uart_tx_prescaled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_prescaled.sv
// UART transmitter with an internal bit-period prescaler; all logic runs on fast_clock.
// Frames are start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_prescaled #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 fast_clock,
    input  logic                 rst,
    uart_tx_prescaled_if.slave   host,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_prescaled: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_prescaled: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_prescaled: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (host.tx_valid && ready_q) begin
                    shreg_d = host.tx_data;
                    par_d   = (^host.tx_data) ^ PAR_INV;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // idx_q is reused to count stop bits
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so each level appears on the edge that enters it
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign ready_d = (state_d == IDLE);
    assign busy_d  = ~ready_d;

    always_ff @(posedge fast_clock) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign host.tx_ready = ready_q;
    assign tx            = tx_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;

endmodule

// File: doc/uart_tx_prescaled.md
# uart_tx_prescaled

Serial UART transmitter that sits directly downstream of `clock_divider`, in the same `fast_clock` domain. It runs its own bit-period prescaler, so the datapath uses only `fast_clock` and never uses a divided clock as a clock. It accepts one parallel word per valid/ready handshake and shifts it out LSB-first on `tx` as start bit, data bits, optional parity and stop bit(s). It is the transmit half of the tx/rx pair.

## Interface
- `CLKS_PER_BIT`, 868: `fast_clock` cycles per serial bit. Must be ≥ 2; violation is an elaboration error.
- `DATA_BITS`, 8: data bits per frame, range 5..9.
- `PARITY_EN`, 0: 1 appends a parity bit after the data.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `fast_clock`  in  1  system clock; every flop is clocked on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  DATA_BITS  word to send; sampled only at handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word; high only in IDLE.
- `tx`  out  1  serial line; idle level 1.
- `tx_busy`  out  1  frame in progress (not IDLE).
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
- **Reset** (`rst`=1 at a rising edge): state=IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; prescaler, bit index and shift register cleared. Reset takes priority over all other activity.
- **States:** IDLE → START → DATA → (PARITY if `PARITY_EN`) → STOP → IDLE.
- **IDLE:** `tx`=1. When `tx_valid`&`tx_ready` is sampled at an edge:
  - latch `tx_data` into the shift register;
  - compute parity: even = XOR of data bits, odd = its inverse;
  - go to START and clear the prescaler.
- **Prescaler:** counter of width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1. The bit ends on the cycle its count equals CLKS_PER_BIT-1; the counter then wraps to 0.
- **START:** `tx`=0 for one bit period, then DATA.
- **DATA:** `tx` = shift-register bit 0. At each bit end, shift right and increment the bit index. After bit DATA_BITS-1 ends, go to PARITY or STOP.
- **PARITY:** `tx` = latched parity bit for one bit period.
- **STOP:** `tx`=1 for STOP_BITS bit periods, then IDLE.
- **`tx_valid` outside IDLE:** ignored. `tx_data` changes outside the handshake edge have no effect on the frame in flight.
- **Reset mid-frame:** the frame is aborted and `tx`=1 from the next edge. No `tx_done` is generated; the word is lost.
- **Outputs** `tx`, `tx_ready`, `tx_busy`, `tx_done` are registered (no combinational path from inputs).

## Timing
- F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits per frame.
- Handshake accepted at edge E:
  - `tx`=0, `tx_busy`=1 and `tx_ready`=0 from E.
  - Data bit i is driven from E+(1+i)·CLKS_PER_BIT.
  - Parity bit, if enabled, is driven from E+(1+DATA_BITS)·CLKS_PER_BIT.
  - Stop level starts after the parity bit, or after the last data bit when parity is disabled.
- At E+F·CLKS_PER_BIT: `tx_ready`=1, `tx_busy`=0, and `tx_done`=1 for exactly one clock.
- Earliest next accept is edge E+F·CLKS_PER_BIT+1, so back-to-back frames carry one extra clock of stop level.
- Every bit lasts exactly CLKS_PER_BIT clocks, with no cumulative drift.
- `tx_valid` held high continuously gives a throughput of one word per F·CLKS_PER_BIT+1 clocks.

## Test plan
- **Reset values:** assert `rst` for 5 clocks with `tx_valid`=1 → during reset and the first clock after it, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, and no start bit appears while `rst` is high.
- **8N1 frame** (`CLKS_PER_BIT`=4, 8N1): send 0xA5 → `tx` reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 clocks. `tx_done` pulses once at E+40 and `tx_ready` is high from E+40.
- **Parity** (`PARITY_EN`=1): send 0x07 with `PARITY_ODD`=0 → parity bit 1; with `PARITY_ODD`=1 → parity bit 0. Frame is 11 bits; `tx_done` at E+44 for `CLKS_PER_BIT`=4.
- **Back-to-back and busy inputs:** hold `tx_valid`=1 with 0x3C, then 0xC3 → two correct frames separated by exactly one extra high clock. Toggling `tx_data`/`tx_valid` mid-frame does not alter the frame.
- **Reset mid-frame:** assert `rst` for 1 clock during data bit 3 of 0xFF → `tx`=1 from the next edge, no `tx_done`, `tx_ready`=1. A following send of 0x55 is transmitted correctly.
- **Two stop bits** (`STOP_BITS`=2, `CLKS_PER_BIT`=868): send 0x00 → line is low for 9·868 clocks, then high for 2·868 clocks. `tx_done` is at E+11·868.
